// File: rtl/ext_mem_pkg.sv
// rtl/ext_mem_pkg.sv - state encoding and bus constants shared by the external-memory responder
package ext_mem_pkg;

    localparam logic EXT_MEM_RW_WRITE = 1'b1;
    localparam int   EXT_MEM_ADD_BW   = 24;
    localparam int   EXT_MEM_DATA_BW  = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_RBURST = 3'd2,
        ST_WBURST = 3'd3,
        ST_WWAIT  = 3'd4,
        ST_DONE   = 3'd5
    } ext_mem_state_e;

endpackage

// File: rtl/ext_mem_responder_ram.sv
// rtl/ext_mem_responder_ram.sv - single-port word RAM, registered read, write-first, no reset
module ext_mem_responder_ram
    import ext_mem_pkg::*;
#(
    parameter int DEPTH_BW = 14
) (
    input  logic                       clock_i,
    input  logic                       we_i,
    input  logic [DEPTH_BW-1:0]        addr_i,
    input  logic [EXT_MEM_DATA_BW-1:0] wdata_i,
    output logic [EXT_MEM_DATA_BW-1:0] rdata_o
);

    logic [EXT_MEM_DATA_BW-1:0] mem_q [2**DEPTH_BW];

    always_ff @(posedge clock_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_o       <= wdata_i;
        end else begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/external_memory_responder.sv
// rtl/external_memory_responder.sv - external-memory bus responder backed by a local RAM
// Optional transaction counters: EXT_MEM_RESPONDER_STATS_EN.
module external_memory_responder
    import ext_mem_pkg::*;
#(
    parameter int BLOCK_WORDS = 16,
    parameter int DEPTH_BW    = 14,
    parameter int LATENCY     = 4
) (
    input  logic                       clock_i,
    input  logic                       reset_i,
    input  logic                       mem_req_i,
    input  logic                       mem_reqBlock_i,
    input  logic                       mem_clear_i,
    input  logic                       mem_rw_i,
    input  logic [EXT_MEM_ADD_BW-1:0]  mem_add_i,
    input  logic [EXT_MEM_DATA_BW-1:0] mem_data_i,
    output logic [EXT_MEM_DATA_BW-1:0] mem_data_o,
    output logic                       mem_ready_o,
    output logic                       mem_valid_o,
    output logic                       mem_done_o,
    output logic [31:0]                stat_reads_o,
    output logic [31:0]                stat_writes_o
);

    localparam int OFF_BW  = $clog2(BLOCK_WORDS);
    localparam int BEAT_BW = OFF_BW + 1;
    localparam int LAT_BW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    ext_mem_state_e state_q, state_d;

    logic [DEPTH_BW-1:0]        base_q;
    logic                       blk_q;
    logic [LAT_BW-1:0]          lat_q;
    logic [BEAT_BW-1:0]         beat_q;
    logic [EXT_MEM_DATA_BW-1:0] data_hold_q;

    logic [DEPTH_BW-1:0]        acc_addr;
    logic [DEPTH_BW-1:0]        blk_mask;
    logic [BEAT_BW-1:0]         last_beat;
    logic [BEAT_BW-1:0]         addr_off;
    logic [DEPTH_BW-1:0]        ram_addr;
    logic                       ram_we;
    logic [EXT_MEM_DATA_BW-1:0] ram_rdata;
    logic [EXT_MEM_ADD_BW-1-DEPTH_BW:0] addr_unused;

    assign addr_unused = mem_add_i[EXT_MEM_ADD_BW-1:DEPTH_BW];
    assign blk_mask    = mem_reqBlock_i ? DEPTH_BW'(BLOCK_WORDS - 1) : '0;
    assign acc_addr    = mem_add_i[DEPTH_BW-1:0] & ~blk_mask;
    assign last_beat   = blk_q ? BEAT_BW'(BLOCK_WORDS - 1) : '0;

    // RAM read is registered, so RBURST runs the address one word ahead of the data.
    always_comb begin
        addr_off = '0;
        ram_addr = base_q;
        ram_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ram_addr = acc_addr;
                ram_we   = mem_req_i && (mem_rw_i == EXT_MEM_RW_WRITE);
            end
            ST_RBURST: begin
                addr_off = beat_q + 1'b1;
                ram_addr = base_q + DEPTH_BW'(addr_off);
            end
            ST_WBURST: begin
                addr_off = beat_q;
                ram_addr = base_q + DEPTH_BW'(addr_off);
                ram_we   = mem_req_i && !mem_clear_i;
            end
            default: ;
        endcase
        if (reset_i) begin
            ram_we = 1'b0;
        end
    end

    ext_mem_responder_ram #(
        .DEPTH_BW(DEPTH_BW)
    ) u_ram (
        .clock_i (clock_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (mem_data_i),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    if (mem_rw_i == EXT_MEM_RW_WRITE) begin
                        state_d = mem_reqBlock_i ? ST_WBURST : ST_WWAIT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT:   if (lat_q == '0) state_d = ST_RBURST;
            ST_RBURST: if (beat_q == last_beat) state_d = ST_DONE;
            ST_WBURST: if (mem_req_i && beat_q == last_beat) state_d = ST_WWAIT;
            ST_WWAIT:  if (lat_q == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && mem_clear_i) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        mem_ready_o = 1'b0;
        mem_valid_o = 1'b0;
        mem_done_o  = 1'b0;
        mem_data_o  = data_hold_q;
        case (state_q)
            ST_IDLE, ST_WBURST: mem_ready_o = 1'b1;
            ST_RBURST: begin
                mem_valid_o = 1'b1;
                mem_data_o  = ram_rdata;
            end
            ST_DONE: mem_done_o = 1'b1;
            default: ;
        endcase
    end

    // Writes start at beat 1 because word 0 goes into the RAM on the accept edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            base_q      <= '0;
            blk_q       <= 1'b0;
            lat_q       <= '0;
            beat_q      <= '0;
            data_hold_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        base_q <= acc_addr;
                        blk_q  <= mem_reqBlock_i;
                        lat_q  <= LAT_BW'(LATENCY - 1);
                        beat_q <= (mem_rw_i == EXT_MEM_RW_WRITE) ? BEAT_BW'(1) : '0;
                    end
                end
                ST_WAIT, ST_WWAIT: begin
                    if (lat_q != '0) lat_q <= lat_q - 1'b1;
                end
                ST_RBURST: begin
                    beat_q      <= beat_q + 1'b1;
                    data_hold_q <= ram_rdata;
                end
                ST_WBURST: begin
                    if (mem_req_i && !mem_clear_i) beat_q <= beat_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef EXT_MEM_RESPONDER_STATS_EN
    logic        rw_q;
    logic [31:0] reads_q;
    logic [31:0] writes_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rw_q     <= 1'b0;
            reads_q  <= '0;
            writes_q <= '0;
        end else begin
            if (state_q == ST_IDLE && mem_req_i) rw_q <= mem_rw_i;
            if (state_q == ST_DONE) begin
                if (rw_q == EXT_MEM_RW_WRITE) writes_q <= writes_q + 32'd1;
                else                          reads_q  <= reads_q + 32'd1;
            end
        end
    end

    assign stat_reads_o  = reads_q;
    assign stat_writes_o = writes_q;
`else
    assign stat_reads_o  = '0;
    assign stat_writes_o = '0;
`endif

endmodule

// File: tb/tb_external_memory_responder.sv
// tb/tb_external_memory_responder.sv - randomized self-checking bench for external_memory_responder
module tb_external_memory_responder;

    localparam int B   = 16;
    localparam int DBW = 8;
    localparam int L   = 4;
    localparam int D   = 256;
`ifdef EXT_MEM_RESPONDER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req, blk, clr, rw;
    logic [23:0] add;
    logic [31:0] wdat, rdat;
    logic        ready, valid, done;
    logic [31:0] st_reads, st_writes;

    always #5 clk = ~clk;

    external_memory_responder #(
        .BLOCK_WORDS(B),
        .DEPTH_BW(DBW),
        .LATENCY(L)
    ) dut (
        .clock_i        (clk),
        .reset_i        (reset_i),
        .mem_req_i      (req),
        .mem_reqBlock_i (blk),
        .mem_clear_i    (clr),
        .mem_rw_i       (rw),
        .mem_add_i      (add),
        .mem_data_i     (wdat),
        .mem_data_o     (rdat),
        .mem_ready_o    (ready),
        .mem_valid_o    (valid),
        .mem_done_o     (done),
        .stat_reads_o   (st_reads),
        .stat_writes_o  (st_writes)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    bit          chk_en = 1'b0;
    logic        exp_ready, exp_valid, exp_done;
    logic [31:0] exp_data;
    int          m_reads, m_writes;
    logic [31:0] model_mem [D];

    int          cyc_n = 0;
    int          acc_cyc = 0;
    int          first_valid_rel, last_valid_rel, nvalid, done_rel, ready_back_rel;
    logic [31:0] first_data, last_data;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, ready}, {31'd0, exp_ready});
            check("valid", {31'd0, valid}, {31'd0, exp_valid});
            check("done", {31'd0, done}, {31'd0, exp_done});
            check("data", rdat, exp_data);
            check("stat_reads", st_reads, STATS ? m_reads : 32'd0);
            check("stat_writes", st_writes, STATS ? m_writes : 32'd0);
            check("valid_done_excl", {31'd0, valid & done}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (valid) begin
                if (first_valid_rel < 0) begin
                    first_valid_rel = cyc_n - acc_cyc;
                    first_data = rdat;
                end
                last_valid_rel = cyc_n - acc_cyc;
                last_data = rdat;
                nvalid++;
            end
            if (done && done_rel < 0) done_rel = cyc_n - acc_cyc;
            if (done_rel >= 0 && ready_back_rel < 0 && ready) ready_back_rel = cyc_n - acc_cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic r, input logic v, input logic dn);
        exp_ready = r;
        exp_valid = v;
        exp_done  = dn;
        tick();
    endtask

    task automatic mark_accept();
        acc_cyc = cyc_n;
        first_valid_rel = -1;
        last_valid_rel = -1;
        nvalid = 0;
        done_rel = -1;
        ready_back_rel = -1;
    endtask

    task automatic busy_inputs();
        req  = 1'($urandom);
        rw   = 1'($urandom);
        blk  = 1'($urandom);
        add  = 24'($urandom);
        wdat = $urandom;
        clr  = 1'b0;
    endtask

    task automatic idle_cyc();
        req = 1'b0;
        clr = 1'b0;
        add = 24'($urandom);
        wdat = $urandom;
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    function automatic int block_base(input logic [23:0] a, input bit b);
        int base;
        base = int'(a) % D;
        if (b) base = base - (base % B);
        return base;
    endfunction

    task automatic do_read(input logic [23:0] a, input bit b, input int clr_at);
        int base, n, k;
        n = b ? B : 1;
        base = block_base(a, b);
        req = 1'b1; rw = 1'b0; blk = b; add = a; wdat = $urandom;
        clr = (clr_at == 0);
        mark_accept();
        cyc(1'b1, 1'b0, 1'b0);
        k = 1;
        for (int i = 0; i < L; i++) begin
            busy_inputs();
            clr = (k == clr_at);
            cyc(1'b0, 1'b0, 1'b0);
            if (k == clr_at) begin clr = 1'b0; return; end
            k++;
        end
        for (int i = 0; i < n; i++) begin
            busy_inputs();
            clr = (k == clr_at);
            exp_data = model_mem[base + i];
            cyc(1'b0, 1'b1, 1'b0);
            if (k == clr_at) begin clr = 1'b0; return; end
            k++;
        end
        busy_inputs();
        cyc(1'b0, 1'b0, 1'b1);
        m_reads++;
    endtask

    task automatic do_write(input logic [23:0] a, input bit b, input bit dmode, input logic [31:0] dbase,
                            input int stall_word, input int stall_len, input int stall_pct,
                            input int clr_at, input int rst_at);
        int base, n, k, i, fs;
        bit stall, forced;
        logic [31:0] d;
        n = b ? B : 1;
        base = block_base(a, b);
        d = dmode ? dbase : $urandom;
        req = 1'b1; rw = 1'b1; blk = b; add = a; wdat = d;
        clr = (clr_at == 0);
        mark_accept();
        cyc(1'b1, 1'b0, 1'b0);
        model_mem[base] = d;
        k = 1;
        i = 1;
        fs = stall_len;
        while (i < n) begin
            forced = (i == stall_word + 1) && (fs > 0);
            stall = forced || (int'($urandom % 100) < stall_pct);
            rw = 1'($urandom); blk = 1'($urandom); add = 24'($urandom);
            if (stall) begin
                req = 1'b0;
                wdat = $urandom;
                if (forced) fs--;
            end else begin
                d = dmode ? dbase + i : $urandom;
                req = 1'b1;
                wdat = d;
            end
            clr = (k == clr_at);
            if (k == rst_at) begin
                req = 1'b0;
                reset_i = 1'b1;
            end
            cyc(1'b1, 1'b0, 1'b0);
            if (k == rst_at) begin
                reset_i = 1'b0;
                exp_data = 32'd0;
                m_reads = 0;
                m_writes = 0;
                return;
            end
            if (k == clr_at) begin clr = 1'b0; return; end
            if (!stall) begin
                model_mem[base + i] = d;
                i++;
            end
            k++;
        end
        for (int j = 0; j < L; j++) begin
            busy_inputs();
            clr = (k == clr_at);
            cyc(1'b0, 1'b0, 1'b0);
            if (k == clr_at) begin clr = 1'b0; return; end
            k++;
        end
        busy_inputs();
        cyc(1'b0, 1'b0, 1'b1);
        m_writes++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rb;
        logic [23:0] ra;
        int          rc;
        reset_i = 1'b1; req = 1'b0; blk = 1'b0; clr = 1'b0; rw = 1'b0; add = '0; wdat = '0;
        exp_data = 32'd0; m_reads = 0; m_writes = 0;
        mark_accept();
        repeat (3) tick();
        reset_i = 1'b0;
        chk_en = 1'b1;
        idle_cyc();

        for (int b = 0; b < D / B; b++) begin
            do_write(24'(b * B), 1'b1, 1'b0, 32'd0, -1, 0, 0, -1, -1);
            if (b == 0) check("fill_done_cycle", done_rel, 32'd20);
        end

        do_write(24'h000010, 1'b0, 1'b1, 32'hDEADBEEF, -1, 0, 0, -1, -1);
        check("single_wr_done_cycle", done_rel, 32'd5);
        do_write(24'h000040, 1'b1, 1'b1, 32'd0, -1, 0, 0, -1, -1);

        do_read(24'h000010, 1'b0, -1);
        idle_cyc();
        check("rd1_valid_cycle", first_valid_rel, 32'd5);
        check("rd1_data", first_data, 32'hDEADBEEF);
        check("rd1_done_cycle", done_rel, 32'd6);
        check("rd1_ready_cycle", ready_back_rel, 32'd7);

        do_read(24'hFF0047, 1'b1, -1);
        check("blk_first_cycle", first_valid_rel, 32'd5);
        check("blk_last_cycle", last_valid_rel, 32'd20);
        check("blk_count", nvalid, 32'd16);
        check("blk_done_cycle", done_rel, 32'd21);
        check("blk_first_data", first_data, 32'd0);
        check("blk_last_data", last_data, 32'd15);

        do_write(24'h000080, 1'b1, 1'b1, 32'hA0, 5, 3, 0, -1, -1);
        check("stall_wr_done_cycle", done_rel, 32'd23);
        do_read(24'h000080, 1'b1, -1);
        check("stall_rb_first", first_data, 32'hA0);
        check("stall_rb_last", last_data, 32'hAF);

        do_read(24'h000080, 1'b1, L + 1 + 7);
        check("clr_valid_count", nvalid, 32'd8);
        check("clr_no_done", done_rel, 32'hFFFFFFFF);
        do_read(24'h000010, 1'b0, -1);
        check("after_clr_data", first_data, 32'hDEADBEEF);
        check("after_clr_done", done_rel, 32'd6);

        do_write(24'h000020, 1'b1, 1'b1, 32'h500, -1, 0, 0, -1, 4);
        do_read(24'h000020, 1'b1, -1);
        check("rst_kept_word0", first_data, 32'h500);
        check("rst_read_count", nvalid, 32'd16);

        do_read(24'h000010, 1'b0, 0);
        check("clr_idle_data", first_data, 32'hDEADBEEF);
        check("clr_idle_done", done_rel, 32'd6);

        do_write(24'h000030, 1'b1, 1'b0, 32'd0, -1, 0, 0, 3, -1);
        do_read(24'h000011, 1'b0, -1);
        do_write(24'h000012, 1'b0, 1'b0, 32'd0, -1, 0, 0, -1, -1);
        do_write(24'h000013, 1'b0, 1'b0, 32'd0, -1, 0, 0, -1, -1);
        check("stat_reads_lit", st_reads, STATS ? 32'd3 : 32'd0);
        check("stat_writes_lit", st_writes, STATS ? 32'd2 : 32'd0);

        for (int t = 0; t < 60; t++) begin
            rb = 1'($urandom);
            ra = 24'($urandom);
            rc = ($urandom % 5 == 0) ? int'($urandom_range(1, L + (rb ? B : 1))) : -1;
            if ($urandom % 2 == 0) do_read(ra, rb, rc);
            else do_write(ra, rb, 1'b0, 32'd0, -1, 0, 25, rc, -1);
            if ($urandom % 3 == 0) idle_cyc();
        end
        idle_cyc();
        idle_cyc();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
